secded_decoder: RTL and testbench

Pipelined SECDED (Hamming single-error-correct, double-error-detect) decoder for 32-bit data words carried as 40-bit codewords. It is the receive-side counterpart of the processor's parity encoder: it checks codewords read back from protected storage or links, corrects single-bit errors, flags uncorrectable errors and keeps saturating error statistics. It sits between the protected memory/link read port and the consuming pipeline stage, with a valid/ready handshake on both sides.

---
 rtl/secded_decoder.sv | 118 +++++++++++
 tb/tb_secded_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_decoder.sv
// Two-stage SECDED decoder for 32-bit data in 40-bit Hamming codewords.
// Stage 1 holds the received word, stage 2 holds the corrected result and flags.
module secded_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [39:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err_single,
  output logic             out_err_double,
  output logic [5:0]       out_syndrome,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorrectable
);

  // Hamming position of data bit idx: the (idx+1)-th non-power-of-two position from 3.
  function automatic int data_pos(input int idx);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int p = 3; p < 40; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) pos = p;
        n = n + 1;
      end
    end
    return pos;
  endfunction

  function automatic logic [31:0] check_mask(input int k);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = ((data_pos(i) >> k) & 1) != 0;
    return m;
  endfunction

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        s1_valid_reg;
  logic [38:0] s1_code_reg;
  logic [5:0]  recomputed;
  logic [5:0]  syndrome;
  logic        parity;
  logic [31:0] flip_mask;
  logic [31:0] corrected;
  logic        err_single;
  logic        err_double;
  logic        advance;
  logic        out_xfer;
  logic        unused_reserved;

  assign unused_reserved = in_code[39];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign out_xfer = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_check
      localparam logic [31:0] MASK = check_mask(gi);
      assign recomputed[gi] = ^(s1_code_reg[31:0] & MASK);
    end
    for (gi = 0; gi < 32; gi++) begin : g_flip
      localparam logic [5:0] POS = 6'(data_pos(gi));
      assign flip_mask[gi] = parity && (syndrome == POS);
    end
  endgenerate

  assign syndrome  = recomputed ^ s1_code_reg[37:32];
  assign parity    = ^s1_code_reg[38:0];
  assign corrected = s1_code_reg[31:0] ^ flip_mask;

  // With odd parity every syndrome up to 38 names a correctable position (0 = overall bit).
  assign err_single = parity && (syndrome <= 6'd38);
  assign err_double = (parity && (syndrome > 6'd38)) || (!parity && (syndrome != 6'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_code_reg    <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_err_single <= 1'b0;
      out_err_double <= 1'b0;
      out_syndrome   <= '0;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      if (in_valid) s1_code_reg <= in_code[38:0];
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data       <= corrected;
        out_err_single <= err_single;
        out_err_double <= err_double;
        out_syndrome   <= syndrome;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else begin
      if (out_xfer && out_err_single && (cnt_corrected != CNT_MAX))
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (out_xfer && out_err_double && (cnt_uncorrectable != CNT_MAX))
        cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_secded_decoder.sv
// Directed and random checks of secded_decoder with a cycle model of the
// handshake and a queue of expected results.
module tb_secded_decoder;

  typedef struct packed {
    logic [31:0] data;
    logic        sgl;
    logic        dbl;
    logic [5:0]  syn;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [39:0] in_code = '0;
  logic        out_ready = 1'b0;
  logic        cnt_clear = 1'b0;

  logic        in_ready, out_valid, out_err_single, out_err_double;
  logic [31:0] out_data;
  logic [5:0]  out_syndrome;
  logic [15:0] cnt_corrected, cnt_uncorrectable;

  logic        in_ready2, out_valid2, out_err_single2, out_err_double2;
  logic [31:0] out_data2;
  logic [5:0]  out_syndrome2;
  logic [1:0]  cnt_corrected2, cnt_uncorrectable2;

  int n_vec = 0;
  int n_bad = 0;

  bit   m_s1 = 0;
  bit   m_out = 0;
  int   m_cc = 0, m_cu = 0, m2_cc = 0, m2_cu = 0;
  res_t q[$];

  always #5 clk = ~clk;

  secded_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_single(out_err_single), .out_err_double(out_err_double),
    .out_syndrome(out_syndrome), .cnt_clear(cnt_clear),
    .cnt_corrected(cnt_corrected), .cnt_uncorrectable(cnt_uncorrectable)
  );

  secded_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_err_single(out_err_single2), .out_err_double(out_err_double2),
    .out_syndrome(out_syndrome2), .cnt_clear(cnt_clear),
    .cnt_corrected(cnt_corrected2), .cnt_uncorrectable(cnt_uncorrectable2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dpos(input int j);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int p = 3; p <= 38; p++) begin
      if ($countones(p) != 1) begin
        if (n == j) r = p;
        n++;
      end
    end
    return r;
  endfunction

  function automatic logic [39:0] enc(input logic [31:0] d);
    logic [39:0] c;
    c = '0;
    c[31:0] = d;
    for (int j = 0; j < 32; j++)
      for (int k = 0; k < 6; k++)
        if (d[j] && ((dpos(j) >> k) & 1) != 0) c[32+k] = ~c[32+k];
    c[38] = ^c[37:0];
    return c;
  endfunction

  function automatic res_t mk(input logic [31:0] d, input logic s, input logic dd, input logic [5:0] sy);
    res_t r;
    r.data = d; r.sgl = s; r.dbl = dd; r.syn = sy;
    return r;
  endfunction

  function automatic res_t model(input logic [39:0] c);
    int   syn;
    logic o;
    res_t r;
    syn = 0;
    for (int j = 0; j < 32; j++) if (c[j]) syn = syn ^ dpos(j);
    for (int k = 0; k < 6; k++) if (c[32+k]) syn = syn ^ (1 << k);
    o = ^c[38:0];
    r = mk(c[31:0], 1'b0, 1'b0, 6'(syn));
    if (o) begin
      if (syn == 0 || $countones(syn) == 1) r.sgl = 1'b1;
      else if (syn <= 38) begin
        r.sgl = 1'b1;
        for (int j = 0; j < 32; j++) if (dpos(j) == syn) r.data[j] = ~r.data[j];
      end else r.dbl = 1'b1;
    end else if (syn != 0) r.dbl = 1'b1;
    return r;
  endfunction

  // One clock cycle: entered and left on a falling edge.
  task automatic step(input logic vld, input logic [39:0] code, input logic ordy,
                      input logic clr, input res_t e);
    bit   adv;
    res_t f;
    chk("cnt_corrected", 64'(cnt_corrected), 64'(m_cc));
    chk("cnt_uncorrectable", 64'(cnt_uncorrectable), 64'(m_cu));
    chk("cnt_corrected_w2", 64'(cnt_corrected2), 64'(m2_cc));
    chk("cnt_uncorrectable_w2", 64'(cnt_uncorrectable2), 64'(m2_cu));
    in_valid = vld; in_code = code; out_ready = ordy; cnt_clear = clr;
    #1;
    adv = !m_out || ordy;
    chk("in_ready", 64'(in_ready), 64'(adv));
    chk("out_valid", 64'(out_valid), 64'(m_out));
    if (m_out) begin
      if (q.size() == 0) begin
        chk("queue_nonempty", 64'(0), 64'(1));
      end else begin
        f = q[0];
        chk("out_data", 64'(out_data), 64'(f.data));
        chk("out_err_single", 64'(out_err_single), 64'(f.sgl));
        chk("out_err_double", 64'(out_err_double), 64'(f.dbl));
        chk("out_syndrome", 64'(out_syndrome), 64'(f.syn));
        if (ordy) begin
          void'(q.pop_front());
          if (f.sgl) begin
            if (m_cc < 65535) m_cc++;
            if (m2_cc < 3) m2_cc++;
          end
          if (f.dbl) begin
            if (m_cu < 65535) m_cu++;
            if (m2_cu < 3) m2_cu++;
          end
        end
      end
    end
    if (clr) begin m_cc = 0; m_cu = 0; m2_cc = 0; m2_cu = 0; end
    if (adv) begin
      m_out = m_s1;
      m_s1  = vld;
      if (vld) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_flags", 64'({out_err_single, out_err_double}), 64'(0));
    chk("rst_syndrome", 64'(out_syndrome), 64'(0));
    chk("rst_counters", 64'({cnt_corrected, cnt_uncorrectable}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    m_s1 = 0; m_out = 0; q.delete();
    m_cc = 0; m_cu = 0; m2_cc = 0; m2_cu = 0;
  endtask

  initial begin
    logic [39:0] c;
    logic [31:0] d;
    logic [39:0] one;
    one = 40'h1;

    do_reset();

    // Directed codewords from the test plan, streamed back to back.
    step(1'b1, 40'h00_0000_0000, 1'b1, 1'b0, mk(32'h0, 1'b0, 1'b0, 6'h00));
    step(1'b1, 40'h00_0000_0020, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 6'h0A));
    step(1'b1, 40'h00_0000_0003, 1'b1, 1'b0, mk(32'h3, 1'b0, 1'b1, 6'h06));
    step(1'b1, 40'h40_0000_0000, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 6'h00));
    step(1'b1, 40'h00_E000_0000, 1'b1, 1'b0, mk(32'hE000_0000, 1'b0, 1'b1, 6'd39));
    step(1'b1, 40'h80_0000_0020, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 6'h0A));
    step(1'b1, 40'h80_0000_0000, 1'b1, 1'b0, mk(32'h0, 1'b0, 1'b0, 6'h00));
    idle(3);
    chk("directed_cnt_corrected", 64'(cnt_corrected), 64'(3));
    chk("directed_cnt_uncorrectable", 64'(cnt_uncorrectable), 64'(2));

    // Backpressure: four valid words with out_ready toggling 1,0,0,1.
    for (int i = 0; i < 4; i++) begin
      c = enc(32'hA5A5_0000 + 32'(i)) ^ (one << (4 * i));
      step(1'b1, c, (i % 4 == 0 || i % 4 == 3) ? 1'b1 : 1'b0, 1'b0, model(c));
    end
    for (int i = 0; i < 8; i++)
      step(1'b0, '0, (i % 4 == 0 || i % 4 == 3) ? 1'b1 : 1'b0, 1'b0, '0);
    idle(2);

    // Random encoded words with 0..2 flipped bits and random handshakes.
    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      c = enc(d);
      if ($urandom_range(0, 2) != 0) c = c ^ (one << $urandom_range(0, 38));
      if ($urandom_range(0, 2) == 0) c = c ^ (one << $urandom_range(0, 38));
      c[39] = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1)), 1'b0, model(c));
    end
    idle(4);

    // Saturation of the 2-bit counters, then a clear coinciding with a transfer.
    step(1'b0, '0, 1'b1, 1'b1, '0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 40'h00_0000_0020, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 6'h0A));
    idle(3);
    chk("sat_cnt_corrected_w2", 64'(cnt_corrected2), 64'(3));
    step(1'b1, 40'h00_0000_0020, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 6'h0A));
    step(1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b1, '0);
    chk("clear_wins_w2", 64'(cnt_corrected2), 64'(0));
    chk("clear_wins", 64'(cnt_corrected), 64'(0));
    idle(2);

    // Reset in the middle of a stream flushes the pipeline.
    step(1'b1, 40'h00_0000_0003, 1'b1, 1'b0, mk(32'h3, 1'b0, 1'b1, 6'h06));
    step(1'b1, 40'h00_0000_0020, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 6'h0A));
    do_reset();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
